// File: rtl/me_pe.sv
// Systolic motion-estimator processing element: saturating sum of absolute
// differences between a reference pixel and one of two search-pixel streams.
module me_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] R,
    input  logic [DATA_W-1:0] S1,
    input  logic [DATA_W-1:0] S2,
    input  logic              s1s2mux,
    input  logic              newDist,
    output logic [ACC_W-1:0]  Accumulate,
    output logic [DATA_W-1:0] Rpipe
);

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    logic [DATA_W-1:0] search_pix;
    logic [DATA_W-1:0] abs_diff;
    logic [ACC_W-1:0]  diff_ext;
    logic [ACC_W:0]    sum_wide;
    logic [ACC_W-1:0]  acc_next;

    // Ordered subtraction keeps the magnitude exact without a sign bit.
    always_comb begin
        search_pix = s1s2mux ? S1 : S2;
        if (R >= search_pix) begin
            abs_diff = R - search_pix;
        end else begin
            abs_diff = search_pix - R;
        end
        diff_ext = ACC_W'(abs_diff);
        sum_wide = {1'b0, Accumulate} + {1'b0, diff_ext};
    end

    // One guard bit above the accumulator flags overflow; clamp instead of wrapping.
    always_comb begin
        acc_next = diff_ext;
        if (!newDist) begin
            if (sum_wide[ACC_W]) begin
                acc_next = ACC_MAX;
            end else begin
                acc_next = sum_wide[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            Accumulate <= '0;
            Rpipe      <= '0;
        end else begin
            Accumulate <= acc_next;
            Rpipe      <= R;
        end
    end

endmodule

// File: tb/tb_me_pe.sv
// Bench for me_pe: directed scenarios plus random traffic, all checked
// against a simple arithmetic model of the SAD accumulator.
module tb_me_pe;

    logic       clock;
    logic       reset_n;
    logic [7:0] R, S1, S2;
    logic       s1s2mux;
    logic       newDist;
    logic [7:0] Accumulate;
    logic [7:0] Rpipe;

    int n_checks = 0;
    int n_errors = 0;
    int acc_m = 0;
    int rp_m  = 0;

    me_pe #(.DATA_W(8), .ACC_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .R          (R),
        .S1         (S1),
        .S2         (S2),
        .s1s2mux    (s1s2mux),
        .newDist    (newDist),
        .Accumulate (Accumulate),
        .Rpipe      (Rpipe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Apply one sample, clock it, update the model, compare both outputs.
    task automatic step(input int r, input int s1, input int s2, input bit mux,
                        input bit nd, input bit rst_n, input string tag);
        int s, d;
        R = r[7:0]; S1 = s1[7:0]; S2 = s2[7:0];
        s1s2mux = mux; newDist = nd; reset_n = rst_n;
        @(posedge clock);
        #1;
        if (!rst_n) begin
            acc_m = 0;
            rp_m  = 0;
        end else begin
            s = mux ? s1 : s2;
            d = (r >= s) ? r - s : s - r;
            rp_m = r;
            if (nd) acc_m = d;
            else    acc_m = (acc_m + d > 255) ? 255 : acc_m + d;
        end
        chk({tag, "_acc"}, int'(Accumulate), acc_m);
        chk({tag, "_rpipe"}, int'(Rpipe), rp_m);
    endtask

    initial begin
        R = 0; S1 = 0; S2 = 0; s1s2mux = 0; newDist = 0; reset_n = 0;
        #2;

        step(7, 0, 1, 0, 1, 0, "rst0");
        step(7, 0, 1, 0, 1, 0, "rst1");
        chk("rst_acc_const", int'(Accumulate), 0);
        step(7, 0, 1, 0, 1, 1, "release");
        chk("release_acc_const", int'(Accumulate), 6);
        chk("release_rp_const", int'(Rpipe), 7);

        step(3, 0, 5, 0, 1, 1, "new_s2_a");
        step(3, 0, 5, 0, 1, 1, "new_s2_b");
        chk("new_s2_const", int'(Accumulate), 2);

        step(3, 0, 5, 1, 0, 1, "acc_s1_a");
        chk("acc5", int'(Accumulate), 5);
        step(3, 0, 5, 1, 0, 1, "acc_s1_b");
        chk("acc8", int'(Accumulate), 8);
        step(3, 0, 5, 1, 0, 1, "acc_s1_c");
        chk("acc11", int'(Accumulate), 11);

        for (int i = 0; i < 3; i++) begin
            step(250, 0, 5, 1, 0, 1, "sat");
            chk("sat_const", int'(Accumulate), 255);
        end
        step(250, 0, 5, 1, 1, 1, "reload");
        chk("reload_const", int'(Accumulate), 250);

        step(10, 200, 0, 1, 1, 1, "sym_a");
        chk("sym_a_const", int'(Accumulate), 190);
        step(200, 10, 0, 1, 1, 1, "sym_b");
        chk("sym_b_const", int'(Accumulate), 190);

        step(0, 255, 0, 1, 1, 1, "diff_max");
        chk("diff_max_const", int'(Accumulate), 255);
        step(77, 0, 77, 0, 1, 1, "diff_zero");
        chk("diff_zero_const", int'(Accumulate), 0);

        step(100, 0, 9, 1, 1, 1, "pre_mid");
        chk("pre_mid_const", int'(Accumulate), 100);
        step(50, 0, 9, 1, 0, 0, "mid_rst");
        chk("mid_rst_acc_const", int'(Accumulate), 0);
        chk("mid_rst_rp_const", int'(Rpipe), 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 40) != 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
